// File: rtl/cla_pkg.sv
// Shared constants for the multiword carry-lookahead add/sub sequencer.
// FSM state encoding and the default word-adder width.
package cla_pkg;

  localparam int CLA_WORD = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cla_word_add.sv
// Combinational W-bit carry-lookahead adder.
// Kogge-Stone prefix over generate/propagate, carry-in folded into bit 0.
module cla_word_add
  import cla_pkg::*;
#(
  parameter int W = CLA_WORD
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  localparam int L = $clog2(W);

  logic [W-1:0] w_p;
  logic [W-1:0] w_g  [0:L];
  logic [W-1:0] w_pp [0:L-1];

  assign w_p     = a ^ b;
  assign w_g[0]  = (a & b) | {{(W-1){1'b0}}, w_p[0] & ci};
  assign w_pp[0] = w_p;

  // Low bits shift in zeros: their group result is already final.
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    assign w_g[k] = w_g[k-1] |
                    (w_pp[k-1] & (w_g[k-1] << (1 << (k-1))));
    if (k < L) begin : g_p
      assign w_pp[k] = w_pp[k-1] &
                       ~((~w_pp[k-1]) << (1 << (k-1)));
    end
  end

  assign s  = w_p ^ {w_g[L][W-2:0], ci};
  assign co = w_g[L][W-1];

endmodule

// File: rtl/cla_multiword_addsub_seq.sv
// Multiword add/subtract that reuses one WORD-bit CLA over NWORDS cycles,
// LS word first, carry chained through a register.
module cla_multiword_addsub_seq
  import cla_pkg::*;
#(
  parameter int WORD   = CLA_WORD,
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD*NWORDS-1:0] a,
  input  logic [WORD*NWORDS-1:0] b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD*NWORDS-1:0] s,
  output logic                   cout,
  output logic                   ovf
);

  localparam int TW = WORD * NWORDS;
  localparam int IW = $clog2(NWORDS);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [TW-1:0] r_opa;
  logic [TW-1:0] r_opb;
  logic [TW-1:0] r_s;
  logic          r_cout;
  logic          r_ovf;

  logic [WORD-1:0] w_wa;
  logic [WORD-1:0] w_wb;
  logic [WORD-1:0] w_sum;
  logic            w_co;
  logic            w_last;
  logic            w_accept;
  logic            w_run;
  logic            w_cmsb;

  assign w_wa     = r_opa[r_idx*WORD +: WORD];
  assign w_wb     = r_opb[r_idx*WORD +: WORD];
  assign w_last   = (r_idx == IW'(NWORDS-1));
  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_run    = (r_state == ST_RUN);
  assign w_cmsb   = w_wa[WORD-1] ^ w_wb[WORD-1] ^ w_sum[WORD-1];

  cla_word_add #(
    .W (WORD)
  ) u_add (
    .a  (w_wa),
    .b  (w_wb),
    .ci (r_carry),
    .s  (w_sum),
    .co (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opa   <= a;
        r_opb   <= sub ? ~b : b;
        r_carry <= sub;
        r_idx   <= '0;
      end
      if (w_run) begin
        r_s[r_idx*WORD +: WORD] <= w_sum;
        r_carry <= w_co;
        r_idx   <= w_last ? '0 : r_idx + IW'(1);
        if (w_last) begin
          r_cout <= w_co;
          r_ovf  <= w_cmsb ^ w_co;
        end
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_multiword_addsub_seq.sv
// Directed and random checks of the multiword add/sub sequencer
// against a full-width arithmetic model through a result queue.
module tb_cla_multiword_addsub_seq;

  localparam int WORD   = 32;
  localparam int NWORDS = 4;
  localparam int TW     = WORD * NWORDS;
  // one IDLE accept cycle, NWORDS RUN cycles, one DONE cycle
  localparam int PERIOD = NWORDS + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] s;
  logic          cout;
  logic          ovf;

  typedef struct packed {
    logic [TW-1:0] s;
    logic          c;
    logic          v;
  } res_t;

  res_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cla_multiword_addsub_seq #(
    .WORD   (WORD),
    .NWORDS (NWORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  function automatic res_t model(input logic [TW-1:0] x,
                                 input logic [TW-1:0] y,
                                 input logic m);
    logic [TW-1:0] yy;
    logic [TW:0]   r;
    res_t          o;
    yy  = m ? ~y : y;
    r   = {1'b0, x} + {1'b0, yy} + {{TW{1'b0}}, m};
    o.s = r[TW-1:0];
    o.c = r[TW];
    o.v = (x[TW-1] == yy[TW-1]) && (o.s[TW-1] != x[TW-1]);
    return o;
  endfunction

  task automatic chk(input string tag,
                     input logic [TW+1:0] obs,
                     input logic [TW+1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [TW-1:0] x,
                      input logic [TW-1:0] y,
                      input logic m,
                      input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {{(TW+1){1'b0}}, in_ready}, 1);
    a = x;
    b = y;
    sub = m;
    in_valid = 1'b1;
    if (push) q.push_back(model(x, y, m));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~x;
    b = ~y;
    sub = ~m;
  endtask

  // Called #1 after the accepting edge.
  task automatic recv(input string tag, input int hold);
    int   n;
    res_t e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, NWORDS);
    if (q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
      return;
    end
    e = q.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, {{(TW+1){1'b0}}, out_valid}, 1);
      chk({tag, "_hold_ready"}, {{(TW+1){1'b0}}, in_ready}, 0);
      chk({tag, "_hold_s"}, {2'b00, s}, {2'b00, e.s});
      chk({tag, "_hold_cv"}, {{TW{1'b0}}, cout, ovf},
          {{TW{1'b0}}, e.c, e.v});
    end
    chk({tag, "_s"}, {2'b00, s}, {2'b00, e.s});
    chk({tag, "_cout"}, {{(TW+1){1'b0}}, cout}, {{(TW+1){1'b0}}, e.c});
    chk({tag, "_ovf"}, {{(TW+1){1'b0}}, ovf}, {{(TW+1){1'b0}}, e.v});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, {{(TW+1){1'b0}}, out_valid}, 0);
  endtask

  initial begin
    logic [TW-1:0] ones;
    logic [TW-1:0] maxp;
    logic [TW-1:0] minn;
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic          rm;
    res_t          e;
    int            got;
    int            last;

    ones = '1;
    maxp = {1'b0, {(TW-1){1'b1}}};
    minn = {1'b1, {(TW-1){1'b0}}};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", {{(TW+1){1'b0}}, in_ready}, 1);
    chk("rst_out_valid", {{(TW+1){1'b0}}, out_valid}, 0);
    chk("rst_s", {2'b00, s}, 0);
    chk("rst_cv", {{TW{1'b0}}, cout, ovf}, 0);

    send(ones, 1, 1'b0, 1);
    recv("wrap", 0);
    send(5, 7, 1'b1, 1);
    recv("sub_neg", 0);
    send(7, 5, 1'b1, 1);
    recv("sub_pos", 0);
    send(maxp, 1, 1'b0, 1);
    recv("ovf_add", 0);
    send(minn, 1, 1'b1, 1);
    recv("ovf_sub", 0);
    send({4{32'h89ab_cdef}}, {4{32'h7654_3210}}, 1'b0, 1);
    recv("hold", 6);

    // reset during the second RUN cycle
    send({4{32'hdead_beef}}, 3, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", {{(TW+1){1'b0}}, in_ready}, 1);
    chk("midrst_out_valid", {{(TW+1){1'b0}}, out_valid}, 0);
    chk("midrst_s", {2'b00, s}, 0);
    send({4{32'h0000_ffff}}, {4{32'hffff_0001}}, 1'b0, 1);
    recv("post_rst", 0);

    // back-to-back with both handshakes held high
    out_ready = 1'b1;
    in_valid = 1'b1;
    got = 0;
    last = -1;
    for (int c = 0; c < 200 && got < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("b2b_queue", 0, 1);
        end else begin
          e = q.pop_front();
          chk("b2b_s", {2'b00, s}, {2'b00, e.s});
          chk("b2b_cv", {{TW{1'b0}}, cout, ovf},
              {{TW{1'b0}}, e.c, e.v});
        end
        if (last >= 0) chk("b2b_period", c - last, PERIOD);
        last = c;
        got++;
      end
      if (in_ready && got < 8) begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        rm = 1'($urandom_range(0, 1));
        if (got == 3) rb = ra;
        a = ra;
        b = rb;
        sub = rm;
        q.push_back(model(ra, rb, rm));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", got, 8);
    chk("b2b_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
